// File: rtl/hex_display_scan.sv
// Time-multiplexed driver for a four-digit hex display: scans one digit per CLK_DIV cycles,
// blanks anodes for BLANK cycles at each slot start and optionally suppresses leading zeros.
module hex_display_scan #(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned BLANK   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        lz_blank,
    output logic [3:0]  hex,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel
);

    localparam logic [15:0] PcntMax  = 16'(CLK_DIV - 1);
    localparam logic [15:0] BlankLim = 16'(BLANK);

    logic [15:0] disp_q, disp_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        lzb_q, lzb_d;

    always_comb begin
        disp_d = disp_q;
        pcnt_d = pcnt_q + 16'd1;
        idx_d  = idx_q;
        lzb_d  = lz_blank;
        if (load) begin
            disp_d = value;
        end
        if (pcnt_q == PcntMax) begin
            pcnt_d = 16'd0;
            idx_d  = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= 16'd0;
            pcnt_q <= 16'd0;
            idx_q  <= 2'd0;
            lzb_q  <= 1'b0;
        end else begin
            disp_q <= disp_d;
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            lzb_q  <= lzb_d;
        end
    end

    logic [3:0] nib_zero;
    logic       upper_zero;
    logic       suppress;
    logic       in_blank;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nib_zero[i] = (disp_q[4*i +: 4] == 4'd0);
        end
    end

    // A digit is a leading zero only if it and every more-significant digit are zero.
    always_comb begin
        upper_zero = 1'b0;
        unique case (idx_q)
            2'd0: upper_zero = 1'b0;
            2'd1: upper_zero = &nib_zero[3:1];
            2'd2: upper_zero = &nib_zero[3:2];
            2'd3: upper_zero = nib_zero[3];
            default: upper_zero = 1'b0;
        endcase
    end

    always_comb begin
        suppress  = lzb_q & upper_zero;
        in_blank  = (pcnt_q < BlankLim);
        hex       = disp_q[{idx_q, 2'b00} +: 4];
        digit_sel = idx_q;
        if (in_blank || suppress) begin
            an = 4'b1111;
        end else begin
            an = ~(4'b0001 << idx_q);
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// Randomised bench for hex_display_scan: two instances (CLK_DIV=4/BLANK=1 and CLK_DIV=2/BLANK=0)
// compared every cycle against a slot-arithmetic reference model.
module tb_hex_display_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        lz_blank;
    logic [3:0]  hex_a, an_a, hex_b, an_b;
    logic [1:0]  sel_a, sel_b;

    int checks   = 0;
    int failures = 0;

    // Reference state: cycles since reset, displayed value, registered lz_blank.
    int          m_t    = 0;
    logic [15:0] m_disp = 16'd0;
    logic        m_lz   = 1'b0;

    always #5 clk = ~clk;

    hex_display_scan #(.CLK_DIV(4), .BLANK(1)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .lz_blank  (lz_blank),
        .hex       (hex_a),
        .an        (an_a),
        .digit_sel (sel_a)
    );

    hex_display_scan #(.CLK_DIV(2), .BLANK(0)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .lz_blank  (lz_blank),
        .hex       (hex_b),
        .an        (an_b),
        .digit_sel (sel_b)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Returns {hex, an, digit_sel} from the display rules.
    function automatic logic [9:0] model_out(input int t, input logic [15:0] d, input logic lz,
                                             input int cdiv, input int blank);
        int          idx  = (t / cdiv) % 4;
        int          pos  = t % cdiv;
        logic [15:0] rest = d >> (4 * idx);
        logic [3:0]  exp_an;
        if (pos < blank) exp_an = 4'b1111;
        else if (lz && idx != 0 && rest == 16'd0) exp_an = 4'b1111;
        else exp_an = ~(4'b0001 << idx);
        return {rest[3:0], exp_an, 2'(idx)};
    endfunction

    task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic lz);
        logic [9:0] ea, eb;
        rst      = r;
        load     = ld;
        value    = v;
        lz_blank = lz;
        @(posedge clk);
        if (r) begin
            m_t    = 0;
            m_disp = 16'd0;
            m_lz   = 1'b0;
        end else begin
            m_t++;
            if (ld) m_disp = v;
            m_lz = lz;
        end
        #1;
        ea = model_out(m_t, m_disp, m_lz, 4, 1);
        eb = model_out(m_t, m_disp, m_lz, 2, 0);
        check_eq("a_hex", 16'(hex_a), 16'(ea[9:6]));
        check_eq("a_an",  16'(an_a),  16'(ea[5:2]));
        check_eq("a_sel", 16'(sel_a), 16'(ea[1:0]));
        check_eq("b_hex", 16'(hex_b), 16'(eb[9:6]));
        check_eq("b_an",  16'(an_b),  16'(eb[5:2]));
        check_eq("b_sel", 16'(sel_b), 16'(eb[1:0]));
    endtask

    task automatic idle(input int n, input logic lz);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, lz);
    endtask

    initial begin
        logic [15:0] rv;
        logic        rlz;
        rst = 1'b1; load = 1'b0; value = 16'h0; lz_blank = 1'b0;

        // Reset wins over a simultaneous load.
        step(1'b1, 1'b1, 16'hFFFF, 1'b1);
        check_eq("rst_hex", 16'(hex_a), 16'h0);
        check_eq("rst_an_a", 16'(an_a), 16'hF);
        check_eq("rst_an_b", 16'(an_b), 16'hE);
        check_eq("rst_sel", 16'(sel_a), 16'h0);

        step(1'b0, 1'b1, 16'h1A2F, 1'b0);
        idle(20, 1'b0);

        step(1'b0, 1'b1, 16'h0005, 1'b1);
        idle(18, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        idle(18, 1'b0);

        step(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(16, 1'b1);
        step(1'b0, 1'b1, 16'h0100, 1'b1);
        idle(16, 1'b1);

        // Load mid-slot at pcnt=2 (bounded search).
        for (int i = 0; i < 8 && (m_t % 4) != 2; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        check_eq("pcnt_reach2", 16'(m_t % 4), 16'd2);
        step(1'b0, 1'b1, 16'hBEEF, 1'b0);
        idle(16, 1'b0);

        // Reset at idx=2, pcnt=3.
        for (int i = 0; i < 20 && !(((m_t / 4) % 4) == 2 && (m_t % 4) == 3); i++)
            step(1'b0, 1'b0, 16'h0, 1'b0);
        check_eq("reach_idx2_p3", 16'(sel_a), 16'd2);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        check_eq("midrst_hex", 16'(hex_a), 16'h0);
        check_eq("midrst_an", 16'(an_a), 16'hF);
        check_eq("midrst_sel", 16'(sel_a), 16'h0);
        idle(10, 1'b0);

        rlz = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 4; n++) begin
                rv[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            if ($urandom_range(0, 15) == 0) rlz = ~rlz;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, rv, rlz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
